seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Multi-cycle unsigned shift-and-add multiplier for the CPU execute stage.
Accepts two N-bit operands through a valid/ready handshake and iterates one partial-product add per cycle on an internal ripple-carry accumulator adder.
Returns a 2N-bit product plus an overflow flag set when the product does not fit in N bits.
Sits beside the ALU adder; the writeback mux consumes its result.

Parameters:
N, 32, operand width in bits; legal for N >= 2.
CW, $clog2(N), iteration counter width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a/b present.
in_ready  output  1  block can accept operands.
a  input  N  multiplicand, unsigned.
b  input  N  multiplier, unsigned.
out_valid  output  1  product and ovf are valid.
out_ready  input  1  consumer accepts the result.
product  output  2N  a*b, unsigned.
ovf  output  1  high when product[2N-1:N] != 0.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - product = 0; ovf = 0; counter = 0; internal mcand/acc registers = 0.
- States and transitions:
  - IDLE: in_ready = 1.
    - in_valid & in_ready: latch a into mcand, {0, b} into acc.
    - If a == 0 or b == 0: go straight to DONE with product = 0, ovf = 0 (zero shortcut, 1 cycle).
    - Otherwise go to RUN with counter = 0.
  - RUN: in_ready = 0. Each cycle, {carry, hi} = acc[2N-1:N] + (acc[0] ? mcand : 0).
    - The adder returns an N+1-bit sum; carry is the MSB.
    - acc <= {carry, hi, acc[N-1:1]}, i.e. right shift by 1 with carry shifted in.
    - counter increments.
    - After the step with counter == N-1: go to DONE; product <= the new acc; ovf <= |new acc[2N-1:N].
  - DONE: out_valid = 1; product and ovf held stable until out_valid & out_ready.
    - On that handshake: go to IDLE, out_valid drops on the next cycle.
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - N+1 cycles in the normal case.
  - 1 cycle for the zero shortcut.
- Throughput: one operation in flight.
  - in_ready is low in RUN and DONE.
  - in_valid during DONE is not accepted, even if out_ready is high in the same cycle.
  - The next accept can occur no earlier than the cycle after returning to IDLE.
- Operand stability: a and b are sampled only on the accept edge. Changes during RUN or DONE have no effect.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Arithmetic:
  - The accumulator adder is N bits wide with a carry-out. The carry is never dropped, so product is exact for all operands, including all-ones.
  - No signed mode.
- Reset mid-operation: asserting rst_n = 0 in any state returns all registers to reset values immediately. The in-flight result is discarded, and no out_valid pulse occurs.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - The state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - The default width constant N = 32.
- One sub-module: mul_acc_adder.
  - N-bit combinational ripple-carry adder with a zero carry-in and an (N+1)-bit sum, carry at bit N.
  - Instantiated once for the RUN-state accumulate.
- Control FSM, counter and acc shift register stay in seq_multiplier.

Test Plan:
- Basic multiply: a=3, b=5, out_ready=1.
  - in_ready drops after accept.
  - out_valid rises 33 cycles later with product=15, ovf=0.
  - Back in IDLE one cycle after the handshake.
- Max operands: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF.
  - product=64'hFFFF_FFFE_0000_0001, ovf=1, which checks carry retention.
- Zero shortcut: a=0, b=32'h1234_5678.
  - out_valid on the cycle after accept; product=0, ovf=0.
  - Repeat with a=7, b=0 for the same response.
- Backpressure: a=16'h8000_0000-style case a=32'h0001_0000, b=32'h0001_0000, with out_ready held 0 for 10 cycles in DONE.
  - product=64'h0000_0001_0000_0000 and ovf=1, both held stable.
  - in_valid pulses during DONE are not accepted.
  - Release out_ready: single handshake, then IDLE.
- Operand change and reset: accept a=6, b=7, then change a/b every cycle during RUN.
  - Result is 42.
  - Second run: drop rst_n at RUN cycle 10. All outputs are 0 and in_ready=1 within the reset, and no out_valid appears afterward.
- Random regression: 1000 random a/b pairs with random out_ready stalls.
  - product equals the 64-bit reference a*b, and ovf equals (product >> 32) != 0.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_adder.sv
// N-bit ripple-carry adder for the multiplier accumulate step.
// Carry-in is zero and the carry-out is returned as sum[N].
module mul_acc_adder
  import seq_multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N:0]   sum
);

  logic [N-1:0] s;
  logic         c;

  always_comb begin
    c = 1'b0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    sum = {c, s};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier, one partial product per cycle.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | N accumulate/shift steps in progress
//   DONE  | product valid, held until consumer accepts
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           ovf,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] product_q, product_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   addend;
  logic [N:0]     sum;

  assign addend = acc_q[0] ? mcand_q : '0;

  mul_acc_adder #(.N(N)) u_adder (
    .x   (acc_q[2*N-1:N]),
    .y   (addend),
    .sum (sum)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d = a;
          acc_d   = {{N{1'b0}}, b};
          cnt_d   = '0;
          if ((a == '0) || (b == '0)) begin
            state_d   = DONE;
            product_d = '0;
            ovf_d     = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // carry lands at the top so all-ones operands stay exact
        acc_d = {sum, acc_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d   = DONE;
          product_d = acc_d;
          ovf_d     = |acc_d[2*N-1:N];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products queued at accept, checked at output.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a_i = '0;
  logic [N-1:0]   b_i = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] product;
  logic           ovf;
  logic           busy;

  typedef struct packed {
    logic [2*N-1:0] p;
    logic           o;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf),
    .busy      (busy)
  );

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    e.p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    e.o = (e.p[2*N-1:N] != '0);
    return e;
  endfunction

  // Drives one accepted operation; caller guarantees the DUT is idle.
  task automatic push_op(input logic [N-1:0] x, input logic [N-1:0] y);
    in_valid = 1'b1;
    a_i = x;
    b_i = y;
    sb_q.push_back(model(x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles (accept cycle = 1) until out_valid; returns 0 on timeout.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    vectors++;
    if (product !== '0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: product=%h ovf=%b, required 0 0", product, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    push_op(32'd3, 32'd5);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_accept: in_ready=%b busy=%b, required 0 1", in_ready, busy);
    end
    wait_out(cyc);
    e = sb_q.pop_front();
    vectors++;
    if (cyc != N + 1) begin
      miscompares++;
      $display("FAIL basic_latency: cycles=%0d, required %0d", cyc, N + 1);
    end
    vectors++;
    if (product !== e.p || ovf !== e.o || product !== 64'd15) begin
      miscompares++;
      $display("FAIL basic_product: product=%h ovf=%b, required %h %b", product, ovf, e.p, e.o);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_max();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(cyc);
    e = sb_q.pop_front();
    vectors++;
    if (cyc != N + 1 || product !== 64'hFFFF_FFFE_0000_0001 || ovf !== 1'b1 || product !== e.p) begin
      miscompares++;
      $display("FAIL max_operands: cycles=%0d product=%h ovf=%b, required %0d fffffffe00000001 1", cyc, product, ovf, N + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int   cyc;
    exp_t e;
    logic [N-1:0] xs [2];
    logic [N-1:0] ys [2];
    xs[0] = 32'd0; ys[0] = 32'h1234_5678;
    xs[1] = 32'd7; ys[1] = 32'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_op(xs[k], ys[k]);
      wait_out(cyc);
      e = sb_q.pop_front();
      vectors++;
      if (cyc != 1 || product !== '0 || ovf !== 1'b0 || e.p !== '0) begin
        miscompares++;
        $display("FAIL zero_shortcut_%0d: cycles=%0d product=%h ovf=%b, required 1 0 0", k, cyc, product, ovf);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_idle_%0d: out_valid=%b in_ready=%b, required 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int   cyc;
    int   bad;
    exp_t e;
    out_ready = 1'b0;
    push_op(32'h0001_0000, 32'h0001_0000);
    wait_out(cyc);
    e = sb_q.pop_front();
    vectors++;
    if (cyc != N + 1 || product !== 64'h0000_0001_0000_0000 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_result: cycles=%0d product=%h ovf=%b, required %0d 0000000100000000 1", cyc, product, ovf, N + 1);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e.p || ovf !== e.o) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_operand_change_reset();
    int   cyc;
    int   seen;
    exp_t e;
    out_ready = 1'b1;
    push_op(32'd6, 32'd7);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || product !== 64'd42 || ovf !== 1'b0 || e.p !== 64'd42) begin
      miscompares++;
      $display("FAIL operand_change: out_valid=%b product=%h ovf=%b, required 1 42 0", out_valid, product, ovf);
    end
    @(posedge clk); #1;

    push_op(32'd100, 32'd200);
    void'(sb_q.pop_back());
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== '0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b product=%h ovf=%b, required 0 1 0 0 0",
               out_valid, in_ready, busy, product, ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: out_valid seen %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_random();
    int   cyc;
    int   done;
    exp_t e;
    logic [N-1:0] x;
    logic [N-1:0] y;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0: x = '0;
        1: x = '1;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: y = '0;
        1: y = '1;
        default: y = $urandom;
      endcase
      push_op(x, y);
      cyc = 0;
      done = 0;
      while (!done && cyc < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          e = sb_q.pop_front();
          vectors++;
          if (product !== e.p || ovf !== e.o) begin
            miscompares++;
            $display("FAIL random_%0d: a=%h b=%h product=%h ovf=%b, required %h %b", n, x, y, product, ovf, e.p, e.o);
          end
          done = 1;
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (!done) begin
        vectors++;
        miscompares++;
        $display("FAIL random_timeout_%0d: no result within 200 cycles, required a handshake", n);
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_operand_change_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
